axil_slave_regfile: RTL and testbench

//  Parametrised AXI4-Lite slave with full read and write channels, terminating at a bank of
//  NUM_REGS memory-mapped registers. It is the successor to the read-only AXI-Lite slave.

---
 rtl/axil_pkg.sv | 16 +
 rtl/axil_slave_regfile_if.sv | 36 +++
 rtl/axil_wr_ctrl.sv | 91 +++++++++
 rtl/axil_slave_regfile.sv | 132 +++++++++++++
 tb/tb_axil_slave_regfile.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes, FSM state types and address helper.
// Pure declarations: no latency, no backpressure.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  // Number of address bits that select a byte within one data word.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axil_slave_regfile_if.sv
// AXI4-Lite bus bundle between an interconnect master and a register-file slave.
// Wires only: no latency; valid/ready backpressure on every channel.
interface axil_slave_regfile_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_wr_ctrl.sv
// Write-side handshake FSM: captures AW and W in any order, issues one commit strobe and the B response.
// Latency: BVALID one cycle after the later of AW/W handshakes; AW/W held not-ready until B is accepted.
module axil_wr_ctrl
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    wvalid,
  output logic                    wready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    bvalid,
  input  logic                    bready,
  output logic [1:0]              bresp,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_idx,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_err
);
  localparam int LSB = addr_lsb(DATA_WIDTH);

  wr_state_t               state, state_nxt;
  logic                    aw_held, w_held;
  logic [ADDR_WIDTH-1:0]   awaddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [1:0]              bresp_q;
  logic                    aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0]   addr_sel;

  assign awready  = (state == WR_IDLE) && !aw_held;
  assign wready   = (state == WR_IDLE) && !w_held;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign bvalid   = (state == WR_RESP);
  assign bresp    = bresp_q;

  // A channel arriving this cycle is forwarded directly so a same-edge pair commits immediately.
  assign addr_sel = aw_held ? awaddr_q : awaddr;
  assign wr_idx   = addr_sel >> LSB;
  assign wr_data  = w_held ? wdata_q : wdata;
  assign wr_strb  = w_held ? wstrb_q : wstrb;
  assign wr_en    = (state == WR_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  always_comb begin
    state_nxt = state;
    case (state)
      WR_IDLE: if (wr_en)  state_nxt = WR_RESP;
      WR_RESP: if (bready) state_nxt = WR_IDLE;
      default:             state_nxt = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WR_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
    end else if (wr_en) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        awaddr_q <= awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave terminating on NUM_REGS registers (RW with byte strobes, or RO from user logic).
// Latency: B and R one cycle after handshake; one write and one read outstanding, held until BREADY/RREADY.
module axil_slave_regfile
  import axil_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                             S_AXIL_ACLK,
  input  logic                             S_AXIL_ARESETn,
  axil_slave_regfile_if.slave              s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
  output logic [NUM_REGS-1:0]              reg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]   user_ro_in
);
  localparam int LSB = addr_lsb(DATA_WIDTH);
  localparam int SW  = DATA_WIDTH / 8;
  localparam int IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic clk, rst_n;
  assign clk   = S_AXIL_ACLK;
  assign rst_n = S_AXIL_ARESETn;

  logic                  wr_en, wr_err, wr_commit;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [SW-1:0]         wr_strb;
  logic [IW-1:0]         wr_sel;
  logic                  unused_prot;

  assign unused_prot = ^{s_axil.awprot, s_axil.arprot};

  axil_wr_ctrl #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_wr_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .awvalid (s_axil.awvalid),
    .awready (s_axil.awready),
    .awaddr  (s_axil.awaddr),
    .wvalid  (s_axil.wvalid),
    .wready  (s_axil.wready),
    .wdata   (s_axil.wdata),
    .wstrb   (s_axil.wstrb),
    .bvalid  (s_axil.bvalid),
    .bready  (s_axil.bready),
    .bresp   (s_axil.bresp),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_err  (wr_err)
  );

  assign wr_sel    = wr_idx[IW-1:0];
  assign wr_err    = (wr_idx >= ADDR_WIDTH'(NUM_REGS)) || RO_MASK[wr_sel];
  assign wr_commit = wr_en && !wr_err;

  logic [DATA_WIDTH-1:0] rd_src [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [DATA_WIDTH-1:0] r;
    if (RO_MASK[i]) begin : g_ro
      assign r = RESET_VALUE;
    end else begin : g_rw
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r <= RESET_VALUE;
        end else if (wr_commit && (wr_sel == IW'(i))) begin
          for (int b = 0; b < SW; b++) begin
            if (wr_strb[b]) r[b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end
    end
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = r;
    assign rd_src[i] = RO_MASK[i] ? user_ro_in[i*DATA_WIDTH +: DATA_WIDTH] : r;
  end

  // The pulse lines up with the first BVALID cycle of the committing write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (wr_commit) reg_wr_pulse[wr_sel] <= 1'b1;
    end
  end

  rd_state_t             rd_state, rd_state_nxt;
  logic                  ar_hs, rd_in_range;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [IW-1:0]         rd_sel;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  assign s_axil.arready = (rd_state == RD_IDLE);
  assign s_axil.rvalid  = (rd_state == RD_DATA);
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;
  assign ar_hs          = s_axil.arvalid && s_axil.arready;
  assign rd_idx         = s_axil.araddr >> LSB;
  assign rd_sel         = rd_idx[IW-1:0];
  assign rd_in_range    = rd_idx < ADDR_WIDTH'(NUM_REGS);

  always_comb begin
    rd_state_nxt = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs)         rd_state_nxt = RD_DATA;
      RD_DATA: if (s_axil.rready) rd_state_nxt = RD_IDLE;
      default:                    rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_state <= RD_IDLE;
    else        rd_state <= rd_state_nxt;
  end

  // Sampled on the AR edge only, so a write committing on the same edge is not yet visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_in_range ? rd_src[rd_sel] : '0;
      rresp_q <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed bench for the AXI4-Lite register file: vector table plus hand-written multi-cycle sequences.
module tb_axil_slave_regfile;
  import axil_pkg::*;

  localparam int NR = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axil_slave_regfile_if #(.ADDR_WIDTH(32), .DATA_WIDTH(DW)) bus ();
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] user_ro_in;
  logic [NR-1:0]    reg_wr_pulse;

  axil_slave_regfile #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .RO_MASK    (16'h0008),
    .RESET_VALUE(32'h0)
  ) dut (
    .S_AXIL_ACLK   (clk),
    .S_AXIL_ARESETn(rst_n),
    .s_axil        (bus),
    .reg_out       (reg_out),
    .reg_wr_pulse  (reg_wr_pulse),
    .user_ro_in    (user_ro_in)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    return reg_out[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [15:0] pulse);
    int n;
    bus.awvalid = 1'b1; bus.awaddr = a;
    bus.wvalid  = 1'b1; bus.wdata  = d; bus.wstrb = s;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < 20) begin
      tick();
      n++;
    end
    chk("wr_bvalid_seen", bus.bvalid, 1'b1);
    resp  = bus.bresp;
    pulse = reg_wr_pulse;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    bus.arvalid = 1'b1; bus.araddr = a;
    tick();
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < 20) begin
      tick();
      n++;
    end
    chk("rd_rvalid_seen", bus.rvalid, 1'b1);
    d    = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic [15:0] exp_pulse;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [1:0]       resp;
    logic [15:0]      pulse;
    logic [31:0]      rd;
    logic [NR*DW-1:0] snap;

    vecs[0]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, RESP_OKAY,   32'hDEAD_BEEF, 16'h0000};
    vecs[1]  = '{1'b1, 32'h0000_000C, 32'h1234_5678, 4'hF, RESP_SLVERR, 32'h0,         16'h0000};
    vecs[2]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, RESP_OKAY,   32'hDEAD_BEEF, 16'h0000};
    vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, RESP_SLVERR, 32'h0,         16'h0000};
    vecs[4]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 32'h0,         16'h0000};
    vecs[5]  = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, RESP_OKAY,   32'hA5A5_A5A5, 16'h0000};
    vecs[6]  = '{1'b1, 32'h0000_001B, 32'hCAFE_F00D, 4'hF, RESP_OKAY,   32'h0,         16'h0040};
    vecs[7]  = '{1'b0, 32'h0000_0018, 32'h0,         4'h0, RESP_OKAY,   32'hCAFE_F00D, 16'h0000};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, RESP_OKAY,   32'h0,         16'h0001};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, RESP_OKAY,   32'h0,         16'h0000};
    vecs[10] = '{1'b1, 32'h0000_003C, 32'h8765_4321, 4'h9, RESP_OKAY,   32'h0,         16'h8000};
    vecs[11] = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, RESP_OKAY,   32'h8700_0021, 16'h0000};
    vecs[12] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, RESP_SLVERR, 32'h0,         16'h0000};

    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb  = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0;
    bus.rready  = 1'b0;
    user_ro_in  = '0;
    user_ro_in[3*DW +: DW] = 32'hDEAD_BEEF;
    user_ro_in[0*DW +: DW] = 32'h5555_5555;

    // Reset state
    #1;
    chk("rst_awready", bus.awready, 1'b1);
    chk("rst_wready",  bus.wready,  1'b1);
    chk("rst_arready", bus.arready, 1'b1);
    chk("rst_bvalid",  bus.bvalid,  1'b0);
    chk("rst_rvalid",  bus.rvalid,  1'b0);
    chk("rst_bresp",   bus.bresp,   2'b00);
    chk("rst_rresp",   bus.rresp,   2'b00);
    chk("rst_rdata",   bus.rdata,   32'h0);
    chk("rst_reg_out", reg_out,     '0);
    chk("rst_pulse",   reg_wr_pulse, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // AW and W in the same cycle
    bus.awvalid = 1'b1; bus.awaddr = 32'h08;
    bus.wvalid  = 1'b1; bus.wdata  = 32'hA5A5_A5A5; bus.wstrb = 4'hF;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("t1_bvalid",  bus.bvalid, 1'b1);
    chk("t1_bresp",   bus.bresp, RESP_OKAY);
    chk("t1_pulse",   reg_wr_pulse, 16'h0004);
    chk("t1_reg2",    word(2), 32'hA5A5_A5A5);
    chk("t1_awready", bus.awready, 1'b0);
    tick();
    chk("t1_pulse_once",  reg_wr_pulse, 16'h0000);
    chk("t1_bvalid_hold", bus.bvalid, 1'b1);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("t1_bvalid_done",  bus.bvalid, 1'b0);
    chk("t1_awready_back", bus.awready, 1'b1);

    // W three cycles ahead of AW, single byte strobe
    do_write(32'h14, 32'h1122_3344, 4'hF, resp, pulse);
    chk("t2_init_resp", resp, RESP_OKAY);
    bus.wvalid = 1'b1; bus.wdata = 32'h0000_BB00; bus.wstrb = 4'b0010;
    tick();
    bus.wvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("t2_wready_low", bus.wready, 1'b0);
      chk("t2_no_bvalid",  bus.bvalid, 1'b0);
      tick();
    end
    bus.awvalid = 1'b1; bus.awaddr = 32'h14;
    tick();
    bus.awvalid = 1'b0;
    chk("t2_bvalid",    bus.bvalid, 1'b1);
    chk("t2_pulse",     reg_wr_pulse, 16'h0020);
    chk("t2_reg5",      word(5), 32'h1122_BB44);
    chk("t2_wready_b",  bus.wready, 1'b0);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    chk("t2_wready_back", bus.wready, 1'b1);

    // Read with RREADY held off for five cycles
    bus.arvalid = 1'b1; bus.araddr = 32'h08;
    tick();
    bus.arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_rvalid",  bus.rvalid, 1'b1);
      chk("t3_rdata",   bus.rdata, 32'hA5A5_A5A5);
      chk("t3_arready", bus.arready, 1'b0);
      tick();
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    chk("t3_rvalid_done",  bus.rvalid, 1'b0);
    chk("t3_arready_back", bus.arready, 1'b1);

    // RO source is captured at the AR edge, later changes are not seen
    bus.arvalid = 1'b1; bus.araddr = 32'h0C;
    tick();
    bus.arvalid = 1'b0;
    user_ro_in[3*DW +: DW] = 32'h0BAD_F00D;
    tick();
    chk("ro_sampled_rdata", bus.rdata, 32'hDEAD_BEEF);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    user_ro_in[3*DW +: DW] = 32'hDEAD_BEEF;

    for (int v = 0; v < 13; v++) begin
      if (vecs[v].is_wr) begin
        snap = reg_out;
        do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, resp, pulse);
        chk($sformatf("vec%0d_bresp", v), resp, vecs[v].exp_resp);
        chk($sformatf("vec%0d_pulse", v), pulse, vecs[v].exp_pulse);
        if (vecs[v].exp_resp == RESP_SLVERR)
          chk($sformatf("vec%0d_regs_kept", v), reg_out, snap);
      end else begin
        do_read(vecs[v].addr, rd, resp);
        chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
        chk($sformatf("vec%0d_rresp", v), resp, vecs[v].exp_resp);
      end
    end

    // Write and read of the same register on the same edge: read returns the old value
    bus.awvalid = 1'b1; bus.awaddr = 32'h08;
    bus.wvalid  = 1'b1; bus.wdata  = 32'h5A5A_5A5A; bus.wstrb = 4'hF;
    bus.arvalid = 1'b1; bus.araddr = 32'h08;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    chk("same_edge_rdata", bus.rdata, 32'hA5A5_A5A5);
    chk("same_edge_reg2",  word(2), 32'h5A5A_5A5A);
    chk("same_edge_bvalid", bus.bvalid, 1'b1);
    chk("same_edge_rvalid", bus.rvalid, 1'b1);
    tick();

    // Reset while both responses are pending
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_bvalid",  bus.bvalid, 1'b0);
    chk("arst_rvalid",  bus.rvalid, 1'b0);
    chk("arst_reg_out", reg_out, '0);
    chk("arst_awready", bus.awready, 1'b1);
    chk("arst_arready", bus.arready, 1'b1);
    chk("arst_rdata",   bus.rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_write(32'h10, 32'h1357_9BDF, 4'hF, resp, pulse);
    chk("post_rst_bresp", resp, RESP_OKAY);
    chk("post_rst_pulse", pulse, 16'h0010);
    chk("post_rst_reg4",  word(4), 32'h1357_9BDF);
    do_read(32'h08, rd, resp);
    chk("post_rst_reg2_read", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
